if_stage1: RTL

IF_STAGE1 -- requirements
Module: if_stage1

---
 rtl/if_stage1_if.sv | 25 ++
 rtl/if_stage1.sv | 80 ++++++++
 2 files changed

// File: rtl/if_stage1_if.sv
// rtl/if_stage1_if.sv - fetch-stage control, instruction-memory and downstream PC signals
interface if_stage1_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  stall_i;
    logic                  redirect_valid_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;
    logic                  imem_req_o;
    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] pc_plus4_o;
    logic                  valid_o;
    logic                  fetch_fault_o;

    modport master (
        input  stall_i, redirect_valid_i, redirect_pc_i, imem_gnt_i,
        output imem_req_o, imem_addr_o, pc_o, pc_plus4_o, valid_o, fetch_fault_o
    );

    modport slave (
        output stall_i, redirect_valid_i, redirect_pc_i, imem_gnt_i,
        input  imem_req_o, imem_addr_o, pc_o, pc_plus4_o, valid_o, fetch_fault_o
    );
endinterface

// File: rtl/if_stage1.sv
// rtl/if_stage1.sv - first fetch stage: PC sequencing, imem request, redirect and misalignment fault
module if_stage1 #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic        clk,
    input  logic        rst,
    if_stage1_if.master bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_next4;
    logic                  redirect_misaligned;

    assign pc_next4            = pc_q + DATA_WIDTH'(4);
    assign redirect_misaligned = |bus.redirect_pc_i[1:0];

    assign bus.imem_addr_o = pc_q;
    assign bus.imem_req_o  = (state == FETCH) && !bus.redirect_valid_i && !bus.stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= BOOT;
            pc_q              <= RESET_VECTOR;
            bus.pc_o          <= '0;
            bus.pc_plus4_o    <= '0;
            bus.valid_o       <= 1'b0;
            bus.fetch_fault_o <= 1'b0;
        end else begin
            case (state)
                BOOT, FETCH: begin
                    if (bus.redirect_valid_i) begin
                        // Redirect wins over stall and grant; a granted fetch this cycle is dropped.
                        pc_q        <= bus.redirect_pc_i;
                        bus.valid_o <= 1'b0;
                        if (redirect_misaligned) begin
                            bus.fetch_fault_o <= 1'b1;
                            state             <= FAULT;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (state == BOOT) begin
                        bus.valid_o <= 1'b0;
                        state       <= FETCH;
                    end else if (bus.stall_i) begin
                        state <= FETCH;
                    end else if (bus.imem_gnt_i) begin
                        bus.pc_o       <= pc_q;
                        bus.pc_plus4_o <= pc_next4;
                        bus.valid_o    <= 1'b1;
                        pc_q           <= pc_next4;
                    end else begin
                        bus.valid_o <= 1'b0;
                    end
                end
                FAULT: begin
                    bus.valid_o       <= 1'b0;
                    bus.fetch_fault_o <= 1'b1;
                    if (bus.redirect_valid_i) begin
                        pc_q <= bus.redirect_pc_i;
                        if (!redirect_misaligned) begin
                            bus.fetch_fault_o <= 1'b0;
                            state             <= FETCH;
                        end
                    end
                end
                default: begin
                    state       <= BOOT;
                    bus.valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
